// File: rtl/pe_pre_pkg.sv
// Shared types and width helpers for the pixel pre-processing column streamer.
package pe_pre_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_PADCOL,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } state_e;

  // Width of a counter able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_oh(input int img_h, input int pad);
    return img_h + 2 * pad;
  endfunction

  function automatic int calc_ow(input int img_w, input int pad);
    return img_w + 2 * pad;
  endfunction

  function automatic int calc_aw(input int img_h, input int img_w);
    return width_of(img_h * img_w);
  endfunction

endpackage

// File: rtl/input_col_streamer_if.sv
// Buffer-claim, buffer-read and column-output signals of the column streamer.
interface input_col_streamer_if #(
  parameter int IMG_H = 24,
  parameter int IMG_W = 32,
  parameter int DW    = 8,
  parameter int PAD   = 1
);
  localparam int OH = pe_pre_pkg::calc_oh(IMG_H, PAD);
  localparam int OW = pe_pre_pkg::calc_ow(IMG_W, PAD);
  localparam int AW = pe_pre_pkg::calc_aw(IMG_H, IMG_W);
  localparam int CW = pe_pre_pkg::width_of(OW);

  logic               buf_ready;
  logic               buf_take;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               out_vld;
  logic               out_rdy;
  logic [OH*DW-1:0]   out_data;
  logic [CW-1:0]      out_col;
  logic               frame_done;

  modport master (
    input  buf_ready, rd_data, out_rdy,
    output buf_take, rd_en, rd_addr, out_vld, out_data, out_col, frame_done
  );

  modport slave (
    output buf_ready, rd_data, out_rdy,
    input  buf_take, rd_en, rd_addr, out_vld, out_data, out_col, frame_done
  );

endinterface

// File: rtl/input_col_fetch.sv
// Reads one image column (rows 0..IMG_H-1) from the frame buffer and hands each
// returned pixel to the column register one cycle after its read strobe.
module input_col_fetch
  import pe_pre_pkg::*;
#(
  parameter  int IMG_H = 24,
  parameter  int IMG_W = 32,
  parameter  int DW    = 8,
  localparam int AW    = calc_aw(IMG_H, IMG_W),
  localparam int RW    = width_of(IMG_H + 1)
) (
  input  logic          PEclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [AW-1:0] start_col,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [DW-1:0] wr_data,
  output logic          done
);

  logic          issuing_q, issuing_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cap_vld_q, cap_vld_d;
  logic [RW-1:0] cap_row_q, cap_row_d;
  logic          last_row;

  assign rd_en    = issuing_q && en;
  assign last_row = (row_q == RW'(IMG_H - 1));

  // The address walks down the column by adding the row stride, so no multiplier.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned and no latch is inferred.
    issuing_d = issuing_q;
    row_d     = row_q;
    addr_d    = addr_q;
    cap_vld_d = rd_en;
    cap_row_d = row_q;
    if (start) begin
      issuing_d = 1'b1;
      row_d     = '0;
      addr_d    = start_col;
    end else if (rd_en) begin
      row_d  = row_q + 1'b1;
      addr_d = addr_q + AW'(IMG_W);
      if (last_row) issuing_d = 1'b0;
    end
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      issuing_q <= 1'b0;
      row_q     <= '0;
      addr_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_row_q <= '0;
    end else begin
      issuing_q <= issuing_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      cap_vld_q <= cap_vld_d;
      cap_row_q <= cap_row_d;
    end
  end

  assign rd_addr = rd_en ? addr_q : '0;
  assign wr_en   = cap_vld_q;
  assign wr_row  = cap_row_q;
  assign wr_data = rd_data;
  assign done    = cap_vld_q && (cap_row_q == RW'(IMG_H - 1));

endmodule

// File: rtl/input_col_streamer.sv
// Streams a claimed frame out as padded columns, one column register deep:
// border columns are synthesised, image columns are fetched row by row.
module input_col_streamer
  import pe_pre_pkg::*;
#(
  parameter int IMG_H = 24,
  parameter int IMG_W = 32,
  parameter int DW    = 8,
  parameter int PAD   = 1
) (
  input  logic                 PEclk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DW-1:0]        pad_value,
  input_col_streamer_if.master bus
);

  localparam int OH = calc_oh(IMG_H, PAD);
  localparam int OW = calc_ow(IMG_W, PAD);
  localparam int AW = calc_aw(IMG_H, IMG_W);
  localparam int CW = width_of(OW);
  localparam int RW = width_of(IMG_H + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    c_q, c_d;
  logic [CW-1:0]    c_next;
  logic [DW-1:0]    pad_q, pad_d;
  logic [OH*DW-1:0] col_q, col_d;

  logic             fetch_start;
  logic [AW-1:0]    fetch_col;
  logic             fetch_rd_en;
  logic [AW-1:0]    fetch_rd_addr;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [DW-1:0]    wr_data;
  logic             fetch_done;

  input_col_fetch #(
    .IMG_H (IMG_H),
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_fetch (
    .PEclk     (PEclk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (fetch_start),
    .start_col (fetch_col),
    .rd_en     (fetch_rd_en),
    .rd_addr   (fetch_rd_addr),
    .rd_data   (bus.rd_data),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .done      (fetch_done)
  );

  assign c_next = c_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    pad_d       = pad_q;
    col_d       = col_q;
    fetch_start = 1'b0;
    fetch_col   = '0;

    unique case (state_q)
      ST_IDLE: if (en && bus.buf_ready) state_d = ST_CLAIM;

      ST_CLAIM: begin
        pad_d = pad_value;
        c_d   = '0;
        if (PAD > 0) begin
          state_d = ST_PADCOL;
        end else begin
          state_d     = ST_FETCH;
          fetch_start = 1'b1;
          col_d       = {OH{pad_value}};
        end
      end

      ST_PADCOL: begin
        if (en) begin
          col_d   = {OH{pad_q}};
          state_d = ST_PRESENT;
        end
      end

      ST_FETCH: if (fetch_done) state_d = ST_PRESENT;

      // The next column's fetch starts only on transfer, since the column register is single.
      ST_PRESENT: begin
        if (bus.out_rdy) begin
          if (int'(c_q) == OW - 1) begin
            c_d     = '0;
            state_d = ST_DONE;
          end else begin
            c_d = c_next;
            if ((int'(c_next) < PAD) || (int'(c_next) >= PAD + IMG_W)) begin
              state_d = ST_PADCOL;
            end else begin
              state_d     = ST_FETCH;
              fetch_start = 1'b1;
              fetch_col   = AW'(int'(c_next) - PAD);
              col_d       = {OH{pad_q}};
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Image pixels land below the top border; slice 0 sits at the MSBs.
    if (wr_en) col_d[(OH - 1 - PAD - int'(wr_row)) * DW +: DW] = wr_data;
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      pad_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      pad_q   <= pad_d;
      col_q   <= col_d;
    end
  end

  assign bus.buf_take   = (state_q == ST_CLAIM);
  assign bus.out_vld    = (state_q == ST_PRESENT);
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.out_data   = col_q;
  assign bus.out_col    = c_q;
  assign bus.rd_en      = fetch_rd_en;
  assign bus.rd_addr    = fetch_rd_addr;

endmodule

// File: tb/tb_input_col_streamer.sv
// Directed bench: default 24x32 PAD=1 streamer plus a 4x3 PAD=0 streamer,
// buffer modelled as rd_data = address one cycle after rd_en.
module tb_input_col_streamer;

  localparam int OH_A = 26;

  logic       PEclk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] pad_value;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [OH_A*8-1:0] col1_seen;

  input_col_streamer_if #(.IMG_H(24), .IMG_W(32), .DW(8), .PAD(1)) bus_a ();
  input_col_streamer_if #(.IMG_H(4),  .IMG_W(3),  .DW(8), .PAD(0)) bus_b ();

  input_col_streamer #(.IMG_H(24), .IMG_W(32), .DW(8), .PAD(1)) dut_a (
    .PEclk     (PEclk),
    .rst_n     (rst_n),
    .en        (en),
    .pad_value (pad_value),
    .bus       (bus_a)
  );

  input_col_streamer #(.IMG_H(4), .IMG_W(3), .DW(8), .PAD(0)) dut_b (
    .PEclk     (PEclk),
    .rst_n     (rst_n),
    .en        (en),
    .pad_value (pad_value),
    .bus       (bus_b)
  );

  always #5 PEclk = ~PEclk;

  always @(posedge PEclk) cyc <= cyc + 1;

  always @(posedge PEclk) begin
    if (!rst_n) begin
      bus_a.rd_data <= '0;
      bus_b.rd_data <= '0;
    end else begin
      if (bus_a.rd_en) bus_a.rd_data <= bus_a.rd_addr[7:0];
      if (bus_b.rd_en) bus_b.rd_data <= {4'h0, bus_b.rd_addr};
    end
  end

  // Expected default-config column: border slices/columns are the pad, else (row*32+col)&8'hFF.
  function automatic logic [OH_A*8-1:0] exp_col_a(input int c, input logic [7:0] pv);
    logic [OH_A*8-1:0] v;
    logic [7:0]        px;
    for (int s = 0; s < OH_A; s++) begin
      px = pv;
      if (c >= 1 && c <= 32 && s >= 1 && s <= 24) px = 8'((s - 1) * 32 + (c - 1));
      v[(OH_A - 1 - s) * 8 +: 8] = px;
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pad_value = 8'hA5;
    bus_a.buf_ready = 1'b0; bus_a.out_rdy = 1'b0;
    bus_b.buf_ready = 1'b0; bus_b.out_rdy = 1'b0;
    repeat (3) @(negedge PEclk);
    checks++;
    if ({bus_a.out_vld, bus_a.buf_take, bus_a.rd_en, bus_a.frame_done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b want 0000",
        {bus_a.out_vld, bus_a.buf_take, bus_a.rd_en, bus_a.frame_done});
    end
    checks++;
    if (bus_a.rd_addr !== '0) begin
      errors++; $display("FAIL reset_addr_a: got %h want 0", bus_a.rd_addr);
    end
    checks++;
    if (bus_a.out_data !== '0) begin
      errors++; $display("FAIL reset_data_a: got %h want 0", bus_a.out_data);
    end
    checks++;
    if (bus_a.out_col !== '0) begin
      errors++; $display("FAIL reset_col_a: got %0d want 0", bus_a.out_col);
    end
    checks++;
    if ({bus_b.out_vld, bus_b.buf_take, bus_b.rd_en, bus_b.frame_done} !== 4'b0 ||
        bus_b.out_data !== '0) begin
      errors++; $display("FAIL reset_b: got ctrl %b data %h want 0",
        {bus_b.out_vld, bus_b.buf_take, bus_b.rd_en, bus_b.frame_done}, bus_b.out_data);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge PEclk);
    checks++;
    if (bus_a.out_vld !== 1'b0 || bus_a.buf_take !== 1'b0) begin
      errors++; $display("FAIL idle_no_ready: got vld %b take %b want 0 0",
        bus_a.out_vld, bus_a.buf_take);
    end
  endtask

  // Runs one frame on the default instance; abort_col >= 0 stops after that many transfers.
  task automatic run_frame_a(input string tag, input bit rand_rdy, input bit drop_en,
                             input int abort_col, input int exp_lat);
    logic [OH_A*8-1:0] held_data;
    logic [5:0]        held_col;
    logic [15:0]       lfsr;
    bit stalled, aborted;
    int exp_c, dones, takes, first_rd, first_vld, rd_seen, drop_left;
    int bad_stable, bad_present, bad_addr, bad_en;
    held_data = '0; held_col = '0; lfsr = 16'hACE1;
    stalled = 1'b0; aborted = 1'b0;
    exp_c = 0; dones = 0; takes = 0; first_rd = -1; first_vld = -1; rd_seen = 0;
    drop_left = drop_en ? 5 : 0;
    bad_stable = 0; bad_present = 0; bad_addr = 0; bad_en = 0;
    bus_a.buf_ready = 1'b1;

    for (int n = 0; n < 4000 && dones == 0 && !aborted; n++) begin
      @(posedge PEclk); #1;
      if (drop_en && rd_seen == 10 && drop_left > 0) begin
        en = 1'b0; drop_left--;
      end else begin
        en = 1'b1;
      end
      if (takes > 0) pad_value = 8'h5A;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      bus_a.out_rdy = rand_rdy ? lfsr[0] : 1'b1;

      @(negedge PEclk);
      if (bus_a.buf_take) begin takes++; bus_a.buf_ready = 1'b0; end
      if (bus_a.rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        rd_seen++;
        if (bus_a.out_vld) bad_present++;
      end
      if (!bus_a.rd_en && bus_a.rd_addr !== '0) bad_addr++;
      if (!en && bus_a.rd_en) bad_en++;
      if (bus_a.out_vld && first_rd >= 0 && first_vld < 0) first_vld = cyc;
      if (bus_a.frame_done) dones++;
      if (stalled && (!bus_a.out_vld || bus_a.out_data !== held_data ||
                      bus_a.out_col !== held_col)) bad_stable++;
      if (bus_a.out_vld && !bus_a.out_rdy) begin
        stalled = 1'b1; held_data = bus_a.out_data; held_col = bus_a.out_col;
      end else begin
        stalled = 1'b0;
      end
      if (bus_a.out_vld && bus_a.out_rdy) begin
        checks++;
        if (bus_a.out_col !== 6'(exp_c) || bus_a.out_data !== exp_col_a(exp_c, 8'hA5)) begin
          errors++;
          $display("FAIL %s col%0d: got col %0d data %h, want col %0d data %h", tag, exp_c,
            bus_a.out_col, bus_a.out_data, exp_c, exp_col_a(exp_c, 8'hA5));
        end
        if (exp_c == 1) col1_seen = bus_a.out_data;
        exp_c++;
        if (exp_c == abort_col) aborted = 1'b1;
      end
    end

    if (abort_col >= 0) begin
      checks++;
      if (dones !== 0 || !aborted) begin
        errors++; $display("FAIL %s_partial: got frame_done %0d reached %b, want 0 1",
          tag, dones, aborted);
      end
    end else begin
      checks++;
      if (exp_c !== 34) begin
        errors++; $display("FAIL %s_ncols: got %0d want 34", tag, exp_c);
      end
      checks++;
      if (dones !== 1 || takes !== 1) begin
        errors++; $display("FAIL %s_pulses: got frame_done %0d buf_take %0d want 1 1",
          tag, dones, takes);
      end
      checks++;
      if (first_vld - first_rd !== exp_lat) begin
        errors++; $display("FAIL %s_latency: got %0d want %0d", tag, first_vld - first_rd, exp_lat);
      end
      checks++;
      if (bad_stable !== 0) begin
        errors++; $display("FAIL %s_stall_hold: got %0d unstable cycles want 0", tag, bad_stable);
      end
      checks++;
      if (bad_present !== 0 || bad_en !== 0) begin
        errors++; $display("FAIL %s_rd_gate: got %0d reads in PRESENT %0d with en low want 0 0",
          tag, bad_present, bad_en);
      end
      checks++;
      if (bad_addr !== 0) begin
        errors++; $display("FAIL %s_idle_addr: got %0d nonzero rd_addr want 0", tag, bad_addr);
      end
    end
    pad_value = 8'hA5;
    en        = 1'b1;
  endtask

  task automatic test_col1_values();
    int         sl [7] = '{0, 1, 2, 3, 9, 24, 25};
    logic [7:0] ev [7] = '{8'hA5, 8'h00, 8'h20, 8'h40, 8'h00, 8'hE0, 8'hA5};
    logic [7:0] got;
    for (int i = 0; i < 7; i++) begin
      got = col1_seen[(OH_A - 1 - sl[i]) * 8 +: 8];
      checks++;
      if (got !== ev[i]) begin
        errors++; $display("FAIL col1_slice%0d: got %h want %h", sl[i], got, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int takes, dones, xfers, done1, take2;
    takes = 0; dones = 0; xfers = 0; done1 = -100; take2 = 0;
    bus_a.buf_ready = 1'b1; bus_a.out_rdy = 1'b1; en = 1'b1;
    for (int n = 0; n < 4000 && dones < 2; n++) begin
      @(negedge PEclk);
      if (bus_a.buf_take) begin takes++; if (takes == 2) take2 = cyc; end
      if (bus_a.out_vld && bus_a.out_rdy) xfers++;
      if (bus_a.frame_done) begin dones++; if (dones == 1) done1 = cyc; end
    end
    bus_a.buf_ready = 1'b0;
    checks++;
    if (dones !== 2 || takes !== 2) begin
      errors++; $display("FAIL b2b_pulses: got frame_done %0d buf_take %0d want 2 2", dones, takes);
    end
    checks++;
    if (take2 - done1 !== 2) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles done->take want 2", take2 - done1);
    end
    checks++;
    if (xfers !== 68) begin
      errors++; $display("FAIL b2b_xfers: got %0d want 68", xfers);
    end
  endtask

  task automatic test_pad0();
    logic [31:0] exp_b [3] = '{32'h00030609, 32'h0104070A, 32'h0205080B};
    int exp_c, dones, takes, first_rd, first_vld;
    exp_c = 0; dones = 0; takes = 0; first_rd = -1; first_vld = -1;
    bus_b.buf_ready = 1'b1; bus_b.out_rdy = 1'b1; en = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) begin
      @(negedge PEclk);
      if (bus_b.buf_take) begin takes++; bus_b.buf_ready = 1'b0; end
      if (bus_b.rd_en && first_rd < 0) first_rd = cyc;
      if (bus_b.out_vld && first_vld < 0) first_vld = cyc;
      if (bus_b.out_vld && bus_b.out_rdy) begin
        checks++;
        if (exp_c > 2 || bus_b.out_col !== 2'(exp_c) || bus_b.out_data !== exp_b[exp_c]) begin
          errors++; $display("FAIL pad0_col%0d: got col %0d data %h want col %0d data %h",
            exp_c, bus_b.out_col, bus_b.out_data, exp_c, (exp_c > 2) ? 32'h0 : exp_b[exp_c]);
        end
        exp_c++;
      end
      if (bus_b.frame_done) dones++;
    end
    checks++;
    if (exp_c !== 3 || dones !== 1 || takes !== 1) begin
      errors++; $display("FAIL pad0_frame: got cols %0d done %0d take %0d want 3 1 1",
        exp_c, dones, takes);
    end
    checks++;
    if (first_vld - first_rd !== 5) begin
      errors++; $display("FAIL pad0_latency: got %0d want 5", first_vld - first_rd);
    end
  endtask

  task automatic test_mid_reset();
    run_frame_a("abort", 1'b0, 1'b0, 10, -1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.out_vld, bus_a.buf_take, bus_a.rd_en, bus_a.frame_done} !== 4'b0) begin
      errors++; $display("FAIL async_rst_ctrl: got %b want 0000",
        {bus_a.out_vld, bus_a.buf_take, bus_a.rd_en, bus_a.frame_done});
    end
    checks++;
    if (bus_a.rd_addr !== '0 || bus_a.out_col !== '0) begin
      errors++; $display("FAIL async_rst_addr_col: got addr %h col %0d want 0 0",
        bus_a.rd_addr, bus_a.out_col);
    end
    checks++;
    if (bus_a.out_data !== '0) begin
      errors++; $display("FAIL async_rst_data: got %h want 0", bus_a.out_data);
    end
    repeat (2) @(negedge PEclk);
    rst_n = 1'b1;
    run_frame_a("restart", 1'b0, 1'b0, -1, 25);
  endtask

  initial begin
    test_reset();
    run_frame_a("basic", 1'b0, 1'b0, -1, 25);
    test_col1_values();
    run_frame_a("stall", 1'b1, 1'b0, -1, 25);
    run_frame_a("en_drop", 1'b0, 1'b1, -1, 30);
    test_back_to_back();
    test_pad0();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_col_streamer.md
INPUT_COL_STREAMER -- requirements
Module: input_col_streamer

Interface
REQ-001 SHALL have parameter IMG_H, default 24, meaning image rows, range 1..64.
REQ-002 SHALL have parameter IMG_W, default 32, meaning image columns, range 1..64.
REQ-003 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-004 SHALL have parameter PAD, default 1, meaning border width in pixels, range 0..3.
REQ-005 SHALL have derived constants OH=IMG_H+2*PAD (output column height), OW=IMG_W+2*PAD (output columns per frame), AW=clog2(IMG_H*IMG_W) (address width).
REQ-006 SHALL have port PEclk, input, 1, sole clock; rising-edge only.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port en, input, 1, run enable.
REQ-009 SHALL have port pad_value, input, DW, fill value for border pixels.
REQ-010 SHALL have port buf_ready, input, 1, frame available in the ping-pong buffer.
REQ-011 SHALL have port buf_take, output, 1, one-cycle pulse that claims the frame (ping-pong switch).
REQ-012 SHALL have port rd_en, output, 1, buffer read strobe.
REQ-013 SHALL have port rd_addr, output, AW, read address = row*IMG_W + col.
REQ-014 SHALL have port rd_data, input, DW, read data, valid exactly 1 cycle after rd_en.
REQ-015 SHALL have port out_vld, output, 1, output column valid.
REQ-016 SHALL have port out_rdy, input, 1, consumer ready.
REQ-017 SHALL have port out_data, output, OH*DW, one padded column; slice s (s=0 at MSBs) = output row s.
REQ-018 SHALL have port out_col, output, clog2(OW), index of the presented column.
REQ-019 SHALL have port frame_done, output, 1, one-cycle pulse after the last column transfers.

Function
REQ-020 SHALL implement states IDLE, CLAIM, PADCOL, FETCH, PRESENT, DONE.
REQ-021 IDLE->CLAIM when en&&buf_ready; CLAIM lasts 1 cycle with buf_take=1, samples pad_value into a frame-constant register.
REQ-022 CLAIM->PADCOL if PAD>0, else ->FETCH; column counter c starts at 0.
REQ-023 PADCOL: out_data all slices = sampled pad; out_vld=1 next cycle; no reads issued.
REQ-024 FETCH for image column j=c-PAD: issue rd_en for rows 0..IMG_H-1 on consecutive enabled cycles; capture rd_data into slice r+PAD one cycle later.
REQ-025 In data columns, slices 0..PAD-1 and OH-PAD..OH-1 SHALL equal sampled pad.
REQ-026 out_vld SHALL rise the cycle after the last capture; latency from first rd_en to out_vld = IMG_H+1 cycles with en held high.
REQ-027 PRESENT: out_data, out_col, out_vld held stable until out_vld&&out_rdy; transfer advances c.
REQ-028 After transfer: c<PAD or c>=PAD+IMG_W -> PADCOL; else -> FETCH; after c=OW-1 -> DONE.
REQ-029 No fetch for column c+1 SHALL begin before column c transfers (single column register).
REQ-030 DONE lasts 1 cycle, frame_done=1, then IDLE; buf_ready high in DONE is accepted on the next IDLE cycle.
REQ-031 en=0 SHALL suppress new rd_en and hold state/counters; an already-issued read SHALL still be captured; out handshake continues regardless of en.
REQ-032 buf_ready is ignored outside IDLE; pad_value changes mid-frame have no effect.
REQ-033 rd_addr SHALL be 0 when rd_en=0.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, out_vld=0, buf_take=0, rd_en=0, rd_addr=0, frame_done=0, out_data=0, out_col=0, counters=0.
REQ-035 Reset mid-frame SHALL abandon the frame; no frame_done; next frame restarts at column 0 after release.

Structure
REQ-036 State enum and OH/OW/AW width helper functions SHALL reside in shared package pe_pre_pkg.
REQ-037 Address generation and column capture SHALL be sub-module input_col_fetch (start, en, row counter, rd_en/rd_addr, slice write, done pulse); FSM and handshake remain in top.

Verification
REQ-038 Defaults, rd_data=addr[7:0], pad_value=8'hA5, out_rdy=1 -> 34 columns; cols 0 and 33 all A5; col 1 slice 1..24 = 0,32,64..; slice 0/25 = A5; one frame_done.
REQ-039 Defaults, out_rdy toggled pseudo-randomly -> out_data/out_col stable while stalled, no column lost or duplicated, rd_en never asserted during PRESENT.
REQ-040 en dropped for 5 cycles mid-FETCH -> no rd_en during drop, captured column identical to REQ-038 column, latency extended by exactly 5.
REQ-041 PAD=0, IMG_H=4, IMG_W=3 -> 3 columns, no pad slices, out_col 0..2, first out_vld 5 cycles after first rd_en.
REQ-042 rst_n pulsed low at column 10 -> outputs zero asynchronously, no frame_done; next buf_ready yields full frame from column 0.
REQ-043 buf_ready held high continuously -> one buf_take per frame, back-to-back frames separated by DONE+IDLE+CLAIM.
